// File: rtl/phv_queue_arbiter_pkg.sv
// Shared constants and the round-robin helper for the PHV queue arbiter.
package phv_queue_arbiter_pkg;

  localparam int RMT_PHV_LEN     = 1024;
  localparam int RMT_NUM_QUEUES  = 4;
  localparam int RMT_QSEL_OFFSET = 141;

  typedef logic [1:0] qid_t;

  // First busy queue at or after ptr, wrapping 3->0; returns ptr when none is busy.
  function automatic qid_t rr_pick(input qid_t ptr, input logic [3:0] busy);
    qid_t sel;
    qid_t idx;
    sel = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + qid_t'(k);
      if (busy[idx]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/phv_queue_arbiter_fifo.sv
// Per-queue PHV FIFO: power-of-two depth, registered count, head always visible on rd_data.
module phv_fifo #(
  parameter int PHV_LEN    = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [PHV_LEN-1:0]          wr_data,
  input  logic                        rd_en,
  output logic [PHV_LEN-1:0]          rd_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PHV_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               wr_ok;
  logic               rd_ok;

  // Full is taken from the registered count, so a write to a full queue is dropped
  // even when the same cycle pops it.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phv_queue_arbiter.sv
// Four-queue PHV buffer with round-robin grant toward the deparser.
// Define PHV_ARB_STATS_EN to add per-queue 32-bit drop counters (drop_cnt_0..3).
module phv_queue_arbiter
  import phv_queue_arbiter_pkg::*;
#(
  parameter int PHV_LEN      = RMT_PHV_LEN,
  parameter int C_NUM_QUEUES = RMT_NUM_QUEUES,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in_0,
  input  logic [PHV_LEN-1:0] phv_in_1,
  input  logic [PHV_LEN-1:0] phv_in_2,
  input  logic [PHV_LEN-1:0] phv_in_3,
  input  logic               phv_in_valid_0,
  input  logic               phv_in_valid_1,
  input  logic               phv_in_valid_2,
  input  logic               phv_in_valid_3,
  output logic               phv_fifo_ready_0,
  output logic               phv_fifo_ready_1,
  output logic               phv_fifo_ready_2,
  output logic               phv_fifo_ready_3,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
`ifdef PHV_ARB_STATS_EN
  output logic [31:0]        drop_cnt_0,
  output logic [31:0]        drop_cnt_1,
  output logic [31:0]        drop_cnt_2,
  output logic [31:0]        drop_cnt_3,
`endif
  input  logic               phv_out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PHV_LEN-1:0]      phv_in   [C_NUM_QUEUES];
  logic [PHV_LEN-1:0]      head     [C_NUM_QUEUES];
  logic [CNT_W-1:0]        cnt      [C_NUM_QUEUES];
  logic [C_NUM_QUEUES-1:0] in_vld;
  logic [C_NUM_QUEUES-1:0] fifo_empty;
  logic [C_NUM_QUEUES-1:0] fifo_rdy;
  logic [C_NUM_QUEUES-1:0] rd_en;
  logic [C_NUM_QUEUES-1:0] busy;

  qid_t rr_ptr;
  qid_t rr_grant;
  qid_t grant;
  qid_t grant_held;
  logic grant_hold;
  logic out_vld;
  logic accept;

  assign phv_in[0] = phv_in_0;
  assign phv_in[1] = phv_in_1;
  assign phv_in[2] = phv_in_2;
  assign phv_in[3] = phv_in_3;
  assign in_vld    = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

  assign phv_fifo_ready_0 = fifo_rdy[0];
  assign phv_fifo_ready_1 = fifo_rdy[1];
  assign phv_fifo_ready_2 = fifo_rdy[2];
  assign phv_fifo_ready_3 = fifo_rdy[3];

  for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_q
    phv_fifo #(
      .PHV_LEN    (PHV_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (axis_clk),
      .rst_n   (aresetn),
      .wr_en   (in_vld[q]),
      .wr_data (phv_in[q]),
      .rd_en   (rd_en[q]),
      .rd_data (head[q]),
      .count   (cnt[q]),
      .empty   (fifo_empty[q])
    );
    assign fifo_rdy[q] = (cnt[q] != CNT_W'(FIFO_DEPTH));
  end

  // A grant offered but not taken stays locked so phv_out cannot change under a stall.
  assign busy     = ~fifo_empty;
  assign out_vld  = |busy;
  assign rr_grant = rr_pick(rr_ptr, busy);
  assign grant    = grant_hold ? grant_held : rr_grant;
  assign accept   = out_vld && phv_out_ready;

  always_comb begin
    rd_en = '0;
    for (int q = 0; q < C_NUM_QUEUES; q++) begin
      rd_en[q] = accept && (grant == qid_t'(q));
    end
  end

  assign phv_out_valid = out_vld;
  assign phv_out       = out_vld ? head[grant] : '0;

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr     <= '0;
      grant_hold <= 1'b0;
      grant_held <= '0;
    end else if (accept) begin
      rr_ptr     <= grant + qid_t'(1);
      grant_hold <= 1'b0;
    end else if (out_vld) begin
      grant_hold <= 1'b1;
      grant_held <= grant;
    end else begin
      grant_hold <= 1'b0;
    end
  end

`ifdef PHV_ARB_STATS_EN
  logic [31:0] drop_cnt [C_NUM_QUEUES];

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int q = 0; q < C_NUM_QUEUES; q++) drop_cnt[q] <= '0;
    end else begin
      for (int q = 0; q < C_NUM_QUEUES; q++) begin
        if (in_vld[q] && !fifo_rdy[q]) drop_cnt[q] <= drop_cnt[q] + 32'd1;
      end
    end
  end

  assign drop_cnt_0 = drop_cnt[0];
  assign drop_cnt_1 = drop_cnt[1];
  assign drop_cnt_2 = drop_cnt[2];
  assign drop_cnt_3 = drop_cnt[3];
`endif

endmodule

// File: tb/tb_phv_queue_arbiter.sv
// Scoreboard bench for phv_queue_arbiter; drop counters are checked when PHV_ARB_STATS_EN is defined.
module tb_phv_queue_arbiter;
  import phv_queue_arbiter_pkg::*;

  localparam int PHV_LEN    = RMT_PHV_LEN;
  localparam int FIFO_DEPTH = 4;

  typedef logic [PHV_LEN-1:0] phv_t;

  logic       axis_clk;
  logic       aresetn;
  phv_t       din [4];
  logic [3:0] din_vld;
  logic [3:0] rdy;
  phv_t       phv_out;
  logic       phv_out_valid;
  logic       phv_out_ready;
`ifdef PHV_ARB_STATS_EN
  logic [31:0] drop_cnt [4];
`endif

  phv_t exp_q [$];
  int   n_checks;
  int   n_errors;

  phv_queue_arbiter #(
    .PHV_LEN      (PHV_LEN),
    .C_NUM_QUEUES (4),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .axis_clk         (axis_clk),
    .aresetn          (aresetn),
    .phv_in_0         (din[0]),
    .phv_in_1         (din[1]),
    .phv_in_2         (din[2]),
    .phv_in_3         (din[3]),
    .phv_in_valid_0   (din_vld[0]),
    .phv_in_valid_1   (din_vld[1]),
    .phv_in_valid_2   (din_vld[2]),
    .phv_in_valid_3   (din_vld[3]),
    .phv_fifo_ready_0 (rdy[0]),
    .phv_fifo_ready_1 (rdy[1]),
    .phv_fifo_ready_2 (rdy[2]),
    .phv_fifo_ready_3 (rdy[3]),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
`ifdef PHV_ARB_STATS_EN
    .drop_cnt_0       (drop_cnt[0]),
    .drop_cnt_1       (drop_cnt[1]),
    .drop_cnt_2       (drop_cnt[2]),
    .drop_cnt_3       (drop_cnt[3]),
`endif
    .phv_out_ready    (phv_out_ready)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string tag, input phv_t obs, input phv_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic phv_t mkphv(input int q, input int n);
    phv_t v;
    v = '0;
    v[RMT_QSEL_OFFSET +: 2]  = q[1:0];
    v[31:0]                  = n;
    v[PHV_LEN-1 -: 16]       = 16'hA5A5 ^ n[15:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain", phv_t'(exp_q.size()), '0);
  endtask

  // Every handshake pops the scoreboard; a handshake with nothing expected is an error.
  always @(negedge axis_clk) begin
    if (aresetn && phv_out_valid && phv_out_ready) begin
      if (exp_q.size() == 0) check("spurious_vld", phv_t'(phv_out_valid), '0);
      else                   check("out_data", phv_out, exp_q.pop_front());
    end
  end

  initial begin
    phv_t a;
    phv_t b;
    n_checks      = 0;
    n_errors      = 0;
    aresetn       = 1'b0;
    phv_out_ready = 1'b0;
    din_vld       = '0;
    for (int q = 0; q < 4; q++) din[q] = '0;
    #3;
    check("rst_vld", phv_t'(phv_out_valid), '0);
    check("rst_out", phv_out, '0);
    check("rst_rdy", phv_t'(rdy), phv_t'(4'hF));
    repeat (2) tick();
    aresetn = 1'b1;
    tick();

    // Two PHVs in every queue, then drain: expect q0,q1,q2,q3,q0,q1,q2,q3.
    for (int n = 0; n < 2; n++) begin
      for (int q = 0; q < 4; q++) din[q] = mkphv(q, 16 + n);
      din_vld = 4'hF;
      tick();
    end
    din_vld = '0;
    for (int n = 0; n < 2; n++)
      for (int q = 0; q < 4; q++) exp_q.push_back(mkphv(q, 16 + n));
    check("rr_first_head", phv_out, mkphv(0, 16));
    check("rr_rdy_half", phv_t'(rdy), phv_t'(4'hF));
    phv_out_ready = 1'b1;
    drain();

    // Single PHV into queue 2: visible one cycle later, gone the cycle after.
    a       = mkphv(2, 32);
    din[2]  = a;
    din_vld = 4'b0100;
    exp_q.push_back(a);
    tick();
    din_vld = '0;
    check("lat_vld", phv_t'(phv_out_valid), phv_t'(1'b1));
    check("lat_data", phv_out, a);
    tick();
    check("lat_empty", phv_t'(phv_out_valid), '0);

    // Stall with queue 3 granted; a later queue-0 arrival must not steal the output.
    phv_out_ready = 1'b0;
    a       = mkphv(3, 48);
    b       = mkphv(0, 49);
    din[3]  = a;
    din_vld = 4'b1000;
    tick();
    din_vld = '0;
    exp_q.push_back(a);
    exp_q.push_back(b);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", phv_out, a);
      if (i == 2) begin
        din[0]  = b;
        din_vld = 4'b0001;
      end
      tick();
      din_vld = '0;
    end
    phv_out_ready = 1'b1;
    drain();

    // Overfill queue 1 while stalled: the fifth write is dropped.
    phv_out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      din[1]  = mkphv(1, 64 + n);
      din_vld = 4'b0010;
      tick();
      din_vld = '0;
      if (n < 4) exp_q.push_back(mkphv(1, 64 + n));
      if (n == 2) check("q1_not_full", phv_t'(rdy[1]), phv_t'(1'b1));
      if (n == 3) check("q1_full", phv_t'(rdy[1]), '0);
    end
    check("q1_still_full", phv_t'(rdy[1]), '0);
    check("q1_head", phv_out, mkphv(1, 64));
`ifdef PHV_ARB_STATS_EN
    check("drop_cnt_1", phv_t'(drop_cnt[1]), phv_t'(32'd1));
`endif
    phv_out_ready = 1'b1;
    drain();

    // Queue 0 full: pop and write in the same cycle -> write dropped, count 4->3.
    phv_out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      din[0]  = mkphv(0, 80 + n);
      din_vld = 4'b0001;
      tick();
      din_vld = '0;
      exp_q.push_back(mkphv(0, 80 + n));
    end
    check("q0_full", phv_t'(rdy[0]), '0);
    phv_out_ready = 1'b1;
    din[0]        = mkphv(0, 99);
    din_vld       = 4'b0001;
    tick();
    din_vld       = '0;
    phv_out_ready = 1'b0;
    check("q0_after_pop", phv_t'(rdy[0]), phv_t'(1'b1));
`ifdef PHV_ARB_STATS_EN
    check("drop_cnt_0", phv_t'(drop_cnt[0]), phv_t'(32'd1));
`endif
    din[0]  = mkphv(0, 90);
    din_vld = 4'b0001;
    tick();
    din_vld = '0;
    exp_q.push_back(mkphv(0, 90));
    check("q0_refull", phv_t'(rdy[0]), '0);
    phv_out_ready = 1'b1;
    drain();

    // Reset mid-operation with three queues loaded: nothing may survive.
    phv_out_ready = 1'b0;
    for (int q = 0; q < 3; q++) din[q] = mkphv(q, 112 + q);
    din_vld = 4'b0111;
    tick();
    din_vld = '0;
    check("pre_rst_vld", phv_t'(phv_out_valid), phv_t'(1'b1));
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_vld", phv_t'(phv_out_valid), '0);
    check("mid_rst_out", phv_out, '0);
    check("mid_rst_rdy", phv_t'(rdy), phv_t'(4'hF));
`ifdef PHV_ARB_STATS_EN
    check("mid_rst_drop", phv_t'(drop_cnt[0]), '0);
`endif
    tick();
    aresetn       = 1'b1;
    phv_out_ready = 1'b1;
    repeat (6) tick();
    check("post_rst_idle", phv_t'(phv_out_valid), '0);

    check("sb_empty", phv_t'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phv_queue_arbiter.md
PHV_QUEUE_ARBITER -- requirements
Module: phv_queue_arbiter

Interface
REQ-001 SHALL have parameter PHV_LEN, default 1024, the PHV width in bits.
REQ-002 SHALL have parameter C_NUM_QUEUES, default 4, the number of per-queue inputs (fixed at 4 in this revision).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the entries per queue; a power of two, at least 2.
REQ-004 SHALL have port axis_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports phv_in_0..phv_in_3, input, PHV_LEN bits each: per-queue PHV from the last stage.
REQ-007 SHALL have ports phv_in_valid_0..phv_in_valid_3, input, 1 bit each: per-queue PHV valid.
REQ-008 SHALL have ports phv_fifo_ready_0..phv_fifo_ready_3, output, 1 bit each: per-queue not-full indication.
REQ-009 SHALL have port phv_out, output, PHV_LEN bits: the PHV granted to the deparser.
REQ-010 SHALL have port phv_out_valid, output, 1 bit: phv_out holds a valid PHV.
REQ-011 SHALL have port phv_out_ready, input, 1 bit: the deparser accepts phv_out.

Function
REQ-012 SHALL give each queue i a FIFO of FIFO_DEPTH entries with a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
REQ-013 SHALL drive phv_fifo_ready_i = (count_i != FIFO_DEPTH), combinationally from registered count.
REQ-014 SHALL write phv_in_i on a cycle where phv_in_valid_i=1 and the queue is not full; the entry is readable the next cycle.
REQ-015 SHALL discard phv_in_i when phv_in_valid_i=1 and the queue is full, even if a read of that queue occurs in the same cycle, and leave the FIFO unchanged.
REQ-016 SHALL accept simultaneous valid inputs on several queues in one cycle, each written to its own FIFO independently.
REQ-017 SHALL select a grant by round robin: starting at rr_ptr, the first non-empty queue in ascending order with wrap-around 3->0 is granted.
REQ-018 SHALL assert phv_out_valid whenever any queue is non-empty, and drive phv_out with the head of the granted queue.
REQ-019 SHALL hold the grant, and therefore phv_out, stable while phv_out_valid=1 and phv_out_ready=0, regardless of new arrivals.
REQ-020 SHALL pop the granted queue and set rr_ptr to (grant+1) mod 4 on a cycle where phv_out_valid=1 and phv_out_ready=1.
REQ-021 SHALL, on a same-queue read and write in one cycle with the queue not full, perform both and leave the count unchanged.
REQ-022 SHALL have a minimum latency of 1 cycle from a write into an empty block to phv_out_valid=1, and a throughput of 1 PHV per cycle.

Reset
REQ-023 SHALL, while aresetn=0, asynchronously clear all counts, pointers, rr_ptr and the grant-hold flag.
REQ-024 SHALL hold phv_out_valid=0 and phv_out=0 during reset, with phv_fifo_ready_i=1 since all FIFOs are empty.
REQ-025 SHALL lose any FIFO content present when reset is asserted mid-operation; storage contents need not be cleared.

Configuration
REQ-026 SHALL, when PHV_ARB_STATS_EN is defined, add output port drop_cnt_0..drop_cnt_3 (32 bits each, wrapping, reset to 0), incremented by one per PHV discarded under REQ-015.
REQ-027 SHALL, when PHV_ARB_STATS_EN is undefined, omit the drop_cnt ports and counters entirely, with all other behaviour identical.

Structure
REQ-028 SHALL take PHV_LEN, C_NUM_QUEUES and the queue-select bit offset (141) from the shared rmt package as localparams.
REQ-029 SHALL implement each queue by instantiating one sub-module, phv_fifo (parameters PHV_LEN and FIFO_DEPTH), four times; the arbiter logic stays in the top module.

Verification
REQ-030 SHALL cover: one PHV written to queue 2 at cycle 0 with phv_out_ready=1 -> phv_out_valid=1 at cycle 1 with matching data, and the queue empty at cycle 2.
REQ-031 SHALL cover: queues 0-3 each loaded with 2 PHVs, then ready held at 1 -> output order q0,q1,q2,q3,q0,q1,q2,q3.
REQ-032 SHALL cover: phv_out_ready=0 for 5 cycles while queue 3 holds A, and queue 0 is written mid-stall -> phv_out stays A; after ready the next output is queue 0.
REQ-033 SHALL cover: 5 writes to queue 1 with ready=0 at FIFO_DEPTH=4 -> ready_1=0 after the 4th; the 5th is dropped and drop_cnt_1=1 with PHV_ARB_STATS_EN defined.
REQ-034 SHALL cover: aresetn pulsed low while 3 queues are non-empty -> phv_out_valid=0 immediately, all ready_i=1, and no stale PHV is output after release.
REQ-035 SHALL cover: queue 0 full with a simultaneous pop of queue 0 and a write to queue 0 -> the write is dropped and the count goes 4->3.
